// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the processor trace recorder:
//   - FSM state encoding (IDLE/ARMED/CAPTURE/DONE)
//   - trace entry field offsets and widths, entry width ENTRY_W
//   - pack_entry(): assembles one 32-bit trace entry from a processor sample
// ---------------------------------------------------------------------------
package trace_pkg;

    localparam int ENTRY_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Entry layout, most significant field first.
    localparam int INSTR_LSB = 16;
    localparam int INSTR_W   = 16;
    localparam int ALU_LSB   = 8;
    localparam int ALU_W     = 8;
    localparam int FLAGS_LSB = 4;
    localparam int FLAGS_W   = 4;
    localparam int PCSRC_BIT = 3;
    localparam int LOST_BIT  = 2;
    localparam int SEQ_LSB   = 0;
    localparam int SEQ_W     = 2;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [INSTR_W-1:0] instr,
        input logic [ALU_W-1:0]   alu,
        input logic [FLAGS_W-1:0] flags,
        input logic               pcsrc,
        input logic               lost,
        input logic [SEQ_W-1:0]   seq
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[INSTR_LSB +: INSTR_W] = instr;
        e[ALU_LSB   +: ALU_W]   = alu;
        e[FLAGS_LSB +: FLAGS_W] = flags;
        e[PCSRC_BIT]            = pcsrc;
        e[LOST_BIT]             = lost;
        e[SEQ_LSB   +: SEQ_W]   = seq;
        return e;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
// The head entry is presented combinationally from storage, so a written
// entry is visible on rdata_o the cycle after the push edge.
// A push while full is accepted only when a pop happens on the same edge.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset (pointers/count only)
//   push_i, wdata_i: write request and data
//   pop_i          : remove head entry (ignored when empty)
//   rdata_o        : head entry (undefined content when empty)
//   full_o, empty_o, count_o : occupancy status
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // DEPTH is a power of two, so pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/trace_capture.sv
// ---------------------------------------------------------------------------
// trace_capture
// Trace recorder for the pipelined processor debug outputs. Once armed it
// waits for a masked instruction match, then records CAPTURE_LEN consecutive
// cycles into a FWFT FIFO drained over a valid/ready stream.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   arm                   : arm request (honoured in IDLE and DONE only)
//   trig_instr, trig_mask : trigger value and compare mask (1 = compare bit)
//   Instr, Flags, ALUResult, PCSrc : processor debug outputs being sampled
//   trace_data, trace_valid, trace_ready : FIFO head stream to the reader
//   state, done           : FSM state and DONE indication
//   drop_count            : saturating count of samples lost to a full FIFO
// ---------------------------------------------------------------------------
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int CAPTURE_LEN = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic [15:0] trig_instr,
    input  logic [15:0] trig_mask,
    input  logic [15:0] Instr,
    input  logic [3:0]  Flags,
    input  logic [7:0]  ALUResult,
    input  logic        PCSrc,
    output logic [31:0] trace_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [1:0]  state,
    output logic        done,
    output logic [7:0]  drop_count
);

    localparam logic [15:0] LAST_IDX = 16'(CAPTURE_LEN - 1);

    state_e        state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic          lost_q, lost_d;
    logic [7:0]    drop_q, drop_d;

    logic               trig_hit;
    logic               sample;
    logic               arm_clear;
    logic               accept;
    logic               pop;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign trig_hit = (((Instr ^ trig_instr) & trig_mask) == 16'h0000);

    // FSM next state; also decides whether this cycle is sampled and
    // whether an arm request restarts the window bookkeeping.
    always_comb begin
        state_d   = state_q;
        sample    = 1'b0;
        arm_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    arm_clear = 1'b1;
                end
            end
            ST_ARMED: begin
                if (trig_hit) begin
                    sample  = 1'b1;
                    state_d = (CAPTURE_LEN == 1) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sample = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    arm_clear = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO still takes a sample if the reader frees a slot on the
    // same edge.
    assign pop    = trace_valid && trace_ready;
    assign accept = sample && (!fifo_full || pop);

    // Sample index advances on every sampled cycle, dropped or not, so the
    // seq field of later entries reveals the gap.
    always_comb begin
        idx_d  = idx_q;
        lost_d = lost_q;
        drop_d = drop_q;
        if (arm_clear) begin
            idx_d  = '0;
            lost_d = 1'b0;
            drop_d = '0;
        end else if (sample) begin
            idx_d = idx_q + 16'd1;
            if (accept) begin
                lost_d = 1'b0;
            end else begin
                lost_d = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lost_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lost_q  <= lost_d;
            drop_q  <= drop_d;
        end
    end

    // The entry carries the lost flag as it stood before this sample.
    assign entry = pack_entry(Instr, ALUResult, Flags, PCSrc, lost_q, idx_q[1:0]);

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (entry),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign trace_valid = (fifo_count != '0);
    // Stale storage is never exposed: an empty FIFO reads as zero.
    assign trace_data  = fifo_empty ? '0 : fifo_head;
    assign state       = state_q;
    assign done        = (state_q == ST_DONE);
    assign drop_count  = drop_q;

endmodule
